// File: rtl/aes_pkg.sv
// Shared AES state-geometry helpers: legal block widths, row offsets, byte indexing.
package aes_pkg;

    localparam int unsigned AES_NB   = 4;
    localparam int unsigned AES_ROWS = 4;

    // Rijndael block widths supported by the datapath
    function automatic bit nb_legal(input int unsigned nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // State width in bits for a given column count
    function automatic int unsigned state_w(input int unsigned nb);
        return 32 * nb;
    endfunction

    // Cyclic row shift: {0,1,2,3} for Nb 4/6, {0,1,3,4} for Nb 8
    function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned row);
        if ((nb == 8) && (row >= 2)) begin
            return row + 1;
        end
        return row;
    endfunction

    // Column-major byte position of (row, col) inside the state
    function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
        return (4 * col) + row;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational forward/inverse ShiftRows byte permutation for Nb = 4/6/8.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter  int unsigned NB = AES_NB,
    localparam int unsigned W  = 32 * NB
) (
    input  logic [0:W-1] i_state,
    input  logic         i_decrypt,
    output logic [0:W-1] o_state
);

    if (!nb_legal(NB)) begin : g_illegal_nb
        $error("shift_rows_perm: NB must be 4, 6 or 8");
    end

    // Each output byte is a pure wire mux between its forward and inverse source
    for (genvar r = 0; r < AES_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int unsigned ROW   = r;
            localparam int unsigned COL   = c;
            localparam int unsigned OFF   = shift_offset(NB, ROW);
            localparam int unsigned FWD_C = (COL + OFF) % NB;
            localparam int unsigned INV_C = (COL + NB - OFF) % NB;
            localparam int unsigned DST   = 8 * byte_idx(ROW, COL);
            localparam int unsigned SRC_F = 8 * byte_idx(ROW, FWD_C);
            localparam int unsigned SRC_I = 8 * byte_idx(ROW, INV_C);

            assign o_state[DST +: 8] = i_decrypt ? i_state[SRC_I +: 8] : i_state[SRC_F +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Handshaked ShiftRows/InvShiftRows stage with a 2-entry output buffer.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter  int unsigned NB    = AES_NB,
    parameter  int unsigned TAG_W = 4,
    localparam int unsigned W     = 32 * NB
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_decrypt,
    input  logic [0:W-1]     in_state,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:W-1]     out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_decrypt
);

    localparam int unsigned CNT_W = 2;

    logic [0:W-1]     w_perm;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    logic [CNT_W-1:0] r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [0:W-1]     r_state0;
    logic [0:W-1]     r_state1;
    logic [TAG_W-1:0] r_tag0;
    logic [TAG_W-1:0] r_tag1;
    logic             r_dec0;
    logic             r_dec1;

    shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .i_state   (in_state),
        .i_decrypt (in_decrypt),
        .o_state   (w_perm)
    );

    // Handshake decode and next occupancy
    always_comb begin
        w_push      = in_valid && r_in_ready;
        w_pop       = r_out_valid && out_ready;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Occupancy plus registered ready/valid flags derived from the next count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != CNT_W'(2));
            r_out_valid <= (w_count_nxt != CNT_W'(0));
        end
    end

    // Entry 0 is always the head so outputs come straight from flops; entry 1 shifts up on pop
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state0 <= '0;
            r_tag0   <= '0;
            r_dec0   <= 1'b0;
            r_state1 <= '0;
            r_tag1   <= '0;
            r_dec1   <= 1'b0;
        end else begin
            if (w_push && ((r_count == CNT_W'(0)) || ((r_count == CNT_W'(1)) && w_pop))) begin
                r_state0 <= w_perm;
                r_tag0   <= in_tag;
                r_dec0   <= in_decrypt;
            end else if (w_pop && (r_count == CNT_W'(2))) begin
                r_state0 <= r_state1;
                r_tag0   <= r_tag1;
                r_dec0   <= r_dec1;
            end
            if (w_push && (r_count == CNT_W'(1)) && !w_pop) begin
                r_state1 <= w_perm;
                r_tag1   <= in_tag;
                r_dec1   <= in_decrypt;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_state   = r_state0;
    assign out_tag     = r_tag0;
    assign out_decrypt = r_dec0;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream: queue-based reference model, NB=4 and NB=8 instances.
module tb_shift_rows_stream;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned W4    = 128;
    localparam int unsigned W8    = 256;

    logic             clock = 1'b0;
    logic             reset;

    logic             in_valid, in_ready, in_decrypt;
    logic [0:W4-1]    in_state;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready, out_decrypt;
    logic [0:W4-1]    out_state;
    logic [TAG_W-1:0] out_tag;

    logic             in8_valid, in8_ready, in8_decrypt;
    logic [0:W8-1]    in8_state;
    logic [TAG_W-1:0] in8_tag;
    logic             out8_valid, out8_ready, out8_decrypt;
    logic [0:W8-1]    out8_state;
    logic [TAG_W-1:0] out8_tag;

    always #5 clock = ~clock;

    shift_rows_stream #(.NB(4), .TAG_W(TAG_W)) dut4 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
        .in_state(in_state), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_tag(out_tag), .out_decrypt(out_decrypt)
    );

    shift_rows_stream #(.NB(8), .TAG_W(TAG_W)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_decrypt(in8_decrypt),
        .in_state(in8_state), .in_tag(in8_tag),
        .out_valid(out8_valid), .out_ready(out8_ready), .out_state(out8_state),
        .out_tag(out8_tag), .out_decrypt(out8_decrypt)
    );

    typedef struct {
        logic [0:W4-1]    st;
        logic [TAG_W-1:0] tag;
        logic             dec;
    } ent_t;

    ent_t        q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Textbook rule: out(r,c) = in(r, c +/- C[r] mod Nb), byte k = 4*col + row
    function automatic logic [0:W8-1] ref_perm(input logic [0:W8-1] s, input int nb, input bit dec);
        int            off [4];
        int            src;
        logic [0:W8-1] res;
        if (nb == 8) off = '{0, 1, 3, 4};
        else         off = '{0, 1, 2, 3};
        res = '0;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = dec ? ((c - off[r] + nb) % nb) : ((c + off[r]) % nb);
                res[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [0:W4-1] ref4(input logic [0:W4-1] s, input bit dec);
        logic [0:W8-1] full;
        full = ref_perm({s, 128'b0}, 4, dec);
        return full[0:W4-1];
    endfunction

    function automatic logic [0:W4-1] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [W8-1:0] obs, input logic [W8-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock of the NB=4 instance, advancing the reference FIFO and checking all outputs
    task automatic tick();
        bit   push, pop, rst_s;
        ent_t e;
        rst_s = reset;
        push  = in_valid && (q.size() < 2);
        pop   = out_ready && (q.size() > 0);
        e.st  = ref4(in_state, in_decrypt);
        e.tag = in_tag;
        e.dec = in_decrypt;
        @(posedge clock);
        #1;
        if (rst_s) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready",  in_ready,  q.size() != 2);
        if (q.size() != 0) begin
            chk("head_state", out_state,   q[0].st);
            chk("head_tag",   out_tag,     q[0].tag);
            chk("head_dec",   out_decrypt, q[0].dec);
        end else if (rst_s) begin
            chk("rst_state", out_state,   '0);
            chk("rst_tag",   out_tag,     '0);
            chk("rst_dec",   out_decrypt, '0);
        end
    endtask

    // Single known-answer transfer: accept, check head one edge later, then drain
    task automatic xfer_const(input string name, input logic [0:W4-1] st, input bit dec,
                              input logic [TAG_W-1:0] tag, input logic [0:W4-1] exp);
        out_ready  = 1'b0;
        in_state   = st;
        in_decrypt = dec;
        in_tag     = tag;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        chk({name, "_valid"}, out_valid, 1'b1);
        chk(name, out_state, exp);
        out_ready  = 1'b1;
        tick();
        chk({name, "_drained"}, out_valid, 1'b0);
    endtask

    logic [0:W4-1] st1;
    logic [0:W8-1] idx8, ref8;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_decrypt = 1'b0;
        in_state   = '0;
        in_tag     = '0;
        out_ready  = 1'b0;
        in8_valid  = 1'b0;
        in8_decrypt= 1'b0;
        in8_state  = '0;
        in8_tag    = '0;
        out8_ready = 1'b1;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready",  in_ready,  1'b1);
        chk("reset_out_state", out_state, '0);

        // Known-answer vectors
        xfer_const("fips_fwd", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h5,
                   128'hd4bf5d30e0b452aeb84111f11e2798e5);
        xfer_const("fips_inv", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'h6,
                   128'hd42711aee0bf98f1b8b45de51e415230);
        xfer_const("index_fwd", 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'h7,
                   128'h00050a0f04090e03080d02070c01060b);
        xfer_const("index_inv", 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'h8,
                   128'h000d0a0704010e0b0805020f0c090603);

        // Backpressure: three pushes into a stalled two-entry buffer
        out_ready  = 1'b0;
        st1        = rnd128();
        in_state   = st1;
        in_decrypt = 1'b0;
        in_tag     = 4'd1;
        in_valid   = 1'b1;
        tick();
        in_state   = rnd128();
        in_decrypt = 1'b1;
        in_tag     = 4'd2;
        tick();
        chk("bp_full_ready", in_ready, 1'b0);
        in_state   = rnd128();
        in_decrypt = 1'b0;
        in_tag     = 4'd3;
        for (int i = 0; i < 3; i++) tick();
        chk("bp_hold_tag",   out_tag,   4'd1);
        chk("bp_hold_state", out_state, ref4(st1, 1'b0));
        out_ready  = 1'b1;
        tick();
        chk("bp_order_2", out_tag, 4'd2);
        tick();
        chk("bp_order_3", out_tag, 4'd3);
        in_valid   = 1'b0;
        tick();
        chk("bp_drained", out_valid, 1'b0);

        // Streaming with alternating mode at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_state   = rnd128();
            in_decrypt = i[0];
            in_tag     = 4'(i);
            in_valid   = 1'b1;
            tick();
            chk("stream_valid", out_valid,   1'b1);
            chk("stream_ready", in_ready,    1'b1);
            chk("stream_mode",  out_decrypt, i[0]);
        end
        in_valid = 1'b0;
        tick();

        // Random handshake traffic
        for (int i = 0; i < 80; i++) begin
            in_state   = rnd128();
            in_decrypt = 1'($urandom_range(0, 1));
            in_tag     = 4'($urandom_range(0, 15));
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Reset mid-operation with a coincident push
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = rnd128();
        tick();
        in_state  = rnd128();
        tick();
        chk("pre_reset_full", in_ready, 1'b0);
        in_state  = rnd128();
        in_tag    = 4'hf;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        chk("mid_reset_valid", out_valid, 1'b0);
        chk("mid_reset_state", out_state, '0);
        chk("mid_reset_ready", in_ready,  1'b1);
        tick();
        chk("mid_reset_no_ghost", out_valid, 1'b0);

        // NB=8: byte k = k, forward then inverse back-to-back
        for (int k = 0; k < 32; k++) idx8[8*k +: 8] = 8'(k);
        in8_state   = idx8;
        in8_decrypt = 1'b0;
        in8_tag     = 4'ha;
        in8_valid   = 1'b1;
        tick();
        in8_state   = ~idx8;
        in8_decrypt = 1'b1;
        in8_tag     = 4'hb;
        ref8        = ref_perm(idx8, 8, 1'b0);
        chk("nb8_fwd_valid", out8_valid, 1'b1);
        chk("nb8_fwd_state", out8_state, ref8);
        chk("nb8_r2c0",      out8_state[16 +: 8], 8'h0e);
        chk("nb8_r3c0",      out8_state[24 +: 8], 8'h13);
        chk("nb8_fwd_tag",   out8_tag, 4'ha);
        tick();
        in8_valid   = 1'b0;
        ref8        = ref_perm(~idx8, 8, 1'b1);
        chk("nb8_inv_state", out8_state,   ref8);
        chk("nb8_inv_mode",  out8_decrypt, 1'b1);
        tick();
        chk("nb8_drained", out8_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
